rca_launch_capture: RTL
=======================

// Module: rca_launch_capture
// PURPOSE
//  On-board stimulus/checker for the ripple-carry adder timing experiments: launches operand vectors into the
//  adder under test, captures {cout,sum} a programmable number of clocks later and compares against a golden sum.
//  Reports progress, last result and error count on the DE10-Lite 7-seg displays. Sits beside the adder in the top level.
// PARAMETERS
//  WIDTH          8        adder operand width, legal 1..8
//  NUM_VECTORS    256      vectors per run (vector 0 directed, rest from LFSR), legal 1..65535
//  CAPTURE_DELAY  2        clocks from launch edge to capture edge, legal 1..15
//  SEED           16'hACE1 LFSR seed, must be non-zero
// PORTS
//  MAX10_CLK1_50  in   1      system clock, 50 MHz
//  KEY            in   2      KEY[0]: async active-low reset; KEY[1]: active-low start pushbutton (asynchronous)
//  op_a           out  WIDTH  operand A to adder (registered)
//  op_b           out  WIDTH  operand B to adder (registered)
//  op_cin         out  1      carry-in to adder (registered)
//  sum            in   WIDTH  adder sum
//  cout           in   1      adder carry-out
//  HEX0..HEX5     out  8 each 7-seg, active-low, bit order {dp,g,f,e,d,c,b,a}
// BEHAVIOUR
//  - Reset (KEY[0]=0, async assert, sync deassert): state IDLE; op_a/op_b/op_cin=0; vec_idx=0; err_cnt=0;
//    last_sum=0; lfsr=SEED; all HEX=8'hC0 ('0', dp off).
//  - KEY[1]: 2-flop synchronised; start = registered falling edge. Honoured only in IDLE or DONE, ignored while running.
//  - FSM: IDLE -start-> CLEAR (1 clk: vec_idx=0, err_cnt=0, lfsr=SEED) -> LAUNCH -> WAIT -> CAPTURE -> CHECK
//    -> LAUNCH if vec_idx<NUM_VECTORS-1 (vec_idx++) else DONE. DONE -start-> CLEAR.
//  - LAUNCH (1 clk): operand regs load on exiting edge. Vector 0: a={WIDTH{1}}, b=0, cin=1 (full carry ripple).
//    Vector n>0: a=lfsr[WIDTH-1:0], b=lfsr[15-:WIDTH], cin=lfsr[7]^lfsr[15]; lfsr steps once per LAUNCH for n>0.
//    Golden exp[WIDTH:0]=a+b+cin registered on the same edge.
//  - LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0.
//  - WAIT: CAPTURE_DELAY-1 clks (0 if CAPTURE_DELAY=1). CAPTURE edge is exactly CAPTURE_DELAY clks after launch edge;
//    {cout,sum} sampled into cap_reg there. CHECK (1 clk): if cap_reg!=exp, err_cnt++ (16-bit, saturates at 16'hFFFF).
//  - Per-vector cost: CAPTURE_DELAY+2 clks (LAUNCH + WAIT + CAPTURE + CHECK minus the shared launch edge ... i.e.
//    LAUNCH(1)+WAIT(D-1)+CAPTURE(1)+CHECK(1)).
//  - last_sum = cap_reg[WIDTH-1:0] zero-extended to 8 bits, updated in CHECK.
//  - Operands hold their value outside LAUNCH; no change in DONE/IDLE.
//  - Display (registered, 1 clk after source): HEX5:4 = vec_idx[7:0], HEX3:2 = last_sum, HEX1:0 = err_cnt (8'hFF if
//    err_cnt>255). HEX0 dp lit (0) in DONE; HEX5 dp lit when err_cnt!=0. Hex digits 0-F standard glyphs.
//  - Reset mid-run: immediate return to reset values; no partial result retained.
//  - Unknown/illegal state encodings recover to IDLE.
// STRUCTURE
//  - Shared package rca_tb_pkg: FSM state encoding, LFSR taps/width, 7-seg glyph table constants, SEG_BLANK/SEG_ZERO.
//  - Sub-module hex_to_7seg (4-bit nibble + dp -> 8-bit active-low segments), instanced six times.
//  - Everything else (sync, FSM, LFSR, golden, counters) in this module.
// TESTING
//  1. Reset only: KEY[0] low 20 ns -> all HEX=8'hC0, op_a=op_b=0, op_cin=0, no state change without KEY[1].
//  2. Ideal adder loopback, CAPTURE_DELAY=2, NUM_VECTORS=8, pulse KEY[1] -> first launch a=8'hFF,b=8'h00,cin=1,
//     capture 9'h100; DONE after 8*4 clks + CLEAR; err_cnt=0; HEX0 dp=0, HEX5 dp=1.
//  3. Adder model with sum[0] stuck-at-0 -> err_cnt equals count of vectors with golden bit0=1; HEX5 dp lit.
//  4. Adder model with 3-clk registered delay, CAPTURE_DELAY=2 -> errors; CAPTURE_DELAY=3 -> err_cnt=0.
//  5. KEY[1] pressed mid-run -> ignored, vector sequence unchanged; pressed in DONE -> counters clear, vector 0 re-launched.
//  6. KEY[0] asserted during WAIT -> outputs back to reset values same clk edge (async); subsequent start replays from SEED.

Source files
------------

// File: rtl/rca_tb_pkg.sv
// Shared constants for the adder launch/capture checker:
// FSM states, LFSR polynomial and seven-segment glyphs.
package rca_tb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LAUNCH  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_CHECK   = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  localparam int LFSR_W = 16;

  // x^16+x^14+x^13+x^11+1 -> bits 15,13,12,10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Active-low segments, dp excluded, order {g,f,e,d,c,b,a}
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_ZERO  = 8'hC0;

  function automatic logic [LFSR_W-1:0] lfsr_next(
    input logic [LFSR_W-1:0] s
  );
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/rca_launch_capture_if.sv
// Operand/result bus between the checker and the adder
// under test. master: checker side, slave: adder side.
interface rca_launch_capture_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output op_a, op_b, op_cin,
    input  sum, cout
  );

  modport slave (
    input  op_a, op_b, op_cin,
    output sum, cout
  );
endinterface

// File: rtl/hex_to_7seg.sv
// Nibble to active-low 7-seg, {dp,g,f,e,d,c,b,a}.
// nib_i: hex digit, dp_on_i: 1 lights the dp, seg_o: segments.
module hex_to_7seg
  import rca_tb_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       dp_on_i,
  output logic [7:0] seg_o
);

  assign seg_o = {~dp_on_i, SEG_GLYPHS[nib_i]};

endmodule

// File: rtl/rca_launch_capture.sv
// Launches operands into an external adder, captures {cout,sum}
// CAPTURE_DELAY clocks later, counts mismatches, drives 7-seg.
// Ports: MAX10_CLK1_50 clk; KEY[0] reset_n, KEY[1] start_n;
// adder: operand/result bus; HEX0..HEX5 status displays.
module rca_launch_capture
  import rca_tb_pkg::*;
#(
  parameter int          WIDTH         = 8,
  parameter int          NUM_VECTORS   = 256,
  parameter int          CAPTURE_DELAY = 2,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                 MAX10_CLK1_50,
  input  logic [1:0]           KEY,
  rca_launch_capture_if.master adder,
  output logic [7:0]           HEX0,
  output logic [7:0]           HEX1,
  output logic [7:0]           HEX2,
  output logic [7:0]           HEX3,
  output logic [7:0]           HEX4,
  output logic [7:0]           HEX5
);

  localparam logic [15:0] LAST_IDX =
    16'(NUM_VECTORS - 1);
  localparam logic [3:0] WAIT_LAST =
    4'((CAPTURE_DELAY > 1) ? CAPTURE_DELAY - 2 : 0);

  logic clk;
  logic key_rst_n;
  logic rst_n;

  assign clk       = MAX10_CLK1_50;
  assign key_rst_n = KEY[0];

  // Async assert, sync release
  logic [1:0] rst_sync_q;

  always_ff @(posedge clk or negedge key_rst_n) begin
    if (!key_rst_n) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  // [1:0] synchroniser, [2] previous level for edge detect
  logic [2:0] key1_q;
  logic       start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key1_q  <= 3'b111;
      start_q <= 1'b0;
    end else begin
      key1_q  <= {key1_q[1:0], KEY[1]};
      start_q <= key1_q[2] & ~key1_q[1];
    end
  end

  state_e           state_q, state_d;
  logic [15:0]      vec_idx_q, vec_idx_d;
  logic [15:0]      err_q, err_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             op_cin_q, op_cin_d;
  logic [WIDTH:0]   exp_q, exp_d;
  logic [WIDTH:0]   cap_q, cap_d;
  logic [7:0]       last_q, last_d;
  logic [3:0]       wait_q, wait_d;

  always_comb begin
    state_d   = state_q;
    vec_idx_d = vec_idx_q;
    err_d     = err_q;
    lfsr_d    = lfsr_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_cin_d  = op_cin_q;
    exp_d     = exp_q;
    cap_d     = cap_q;
    last_d    = last_q;
    wait_d    = wait_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_q) state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        vec_idx_d = '0;
        err_d     = '0;
        lfsr_d    = SEED;
        state_d   = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        // Vector 0 forces a carry through every bit
        if (vec_idx_q == '0) begin
          op_a_d   = '1;
          op_b_d   = '0;
          op_cin_d = 1'b1;
        end else begin
          op_a_d   = lfsr_q[WIDTH-1:0];
          op_b_d   = lfsr_q[15 -: WIDTH];
          op_cin_d = lfsr_q[7] ^ lfsr_q[15];
          lfsr_d   = lfsr_next(lfsr_q);
        end
        exp_d = {1'b0, op_a_d}
              + {1'b0, op_b_d}
              + {{WIDTH{1'b0}}, op_cin_d};
        wait_d = '0;
        if (CAPTURE_DELAY == 1) state_d = ST_CAPTURE;
        else                    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wait_d  = wait_q + 4'd1;
      end
      ST_CAPTURE: begin
        cap_d   = {adder.cout, adder.sum};
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (cap_q != exp_q && err_q != 16'hFFFF)
          err_d = err_q + 16'd1;
        last_d = '0;
        last_d[WIDTH-1:0] = cap_q[WIDTH-1:0];
        if (vec_idx_q < LAST_IDX) begin
          vec_idx_d = vec_idx_q + 16'd1;
          state_d   = ST_LAUNCH;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      vec_idx_q <= '0;
      err_q     <= '0;
      lfsr_q    <= SEED;
      op_a_q    <= '0;
      op_b_q    <= '0;
      op_cin_q  <= 1'b0;
      exp_q     <= '0;
      cap_q     <= '0;
      last_q    <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      vec_idx_q <= vec_idx_d;
      err_q     <= err_d;
      lfsr_q    <= lfsr_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_cin_q  <= op_cin_d;
      exp_q     <= exp_d;
      cap_q     <= cap_d;
      last_q    <= last_d;
      wait_q    <= wait_d;
    end
  end

  assign adder.op_a   = op_a_q;
  assign adder.op_b   = op_b_q;
  assign adder.op_cin = op_cin_q;

  // Display: vec_idx | last_sum | err_cnt, MSD on the left
  logic [7:0]      err_disp;
  logic [5:0][3:0] nib;
  logic [5:0]      dp_on;
  logic [5:0][7:0] hex_d, hex_q;

  assign err_disp = (err_q > 16'd255) ? 8'hFF : err_q[7:0];

  always_comb begin
    nib[5] = vec_idx_q[7:4];
    nib[4] = vec_idx_q[3:0];
    nib[3] = last_q[7:4];
    nib[2] = last_q[3:0];
    nib[1] = err_disp[7:4];
    nib[0] = err_disp[3:0];
    dp_on    = '0;
    dp_on[0] = (state_q == ST_DONE);
    dp_on[5] = (err_q != '0);
  end

  for (genvar i = 0; i < 6; i++) begin : g_hex
    hex_to_7seg u_hex (
      .nib_i   (nib[i]),
      .dp_on_i (dp_on[i]),
      .seg_o   (hex_d[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex_q <= {6{SEG_ZERO}};
    else        hex_q <= hex_d;
  end

  assign HEX0 = hex_q[0];
  assign HEX1 = hex_q[1];
  assign HEX2 = hex_q[2];
  assign HEX3 = hex_q[3];
  assign HEX4 = hex_q[4];
  assign HEX5 = hex_q[5];

endmodule
